photobooth_seq: RTL and testbench
=================================

Name: photobooth_seq

Overview:
Parametrised successor to the single-shot photobooth state register. It sequences a multi-shot capture session: preview, per-shot countdown, frame-aligned capture into one of NUM_SHOTS frame buffers, shot review, filter selection and the send handshake. It sits on the 65 MHz domain between start_screen/button logic and the frame-buffer write enables, ditherConv/threshold muxing and the transmit block.

Parameters:
NUM_SHOTS, 4, shots per session (1..8)
COUNTDOWN_FRAMES, 180, frame ticks of countdown before each shot (3 s at 60 Hz)
NUM_MODES, 3, filter modes (0 gray, 1 dither, 2 threshold)

Ports:
clk_in  in  1  system clock (65 MHz)
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  single-cycle pulse, debounced start/shutter
next_in  in  1  single-cycle pulse, cycle selection
accept_in  in  1  single-cycle pulse, confirm selection
cancel_in  in  1  single-cycle pulse, abort session
frame_tick_in  in  1  single-cycle pulse per VGA frame
frame_done_in  in  1  single-cycle pulse, camera frame complete (already synchronised)
send_done_in  in  1  single-cycle pulse from transmitter
state_out  out  3  current state encoding
shot_idx_out  out  $clog2(NUM_SHOTS) (min 1)  buffer being captured
review_sel_out  out  $clog2(NUM_SHOTS) (min 1)  shot selected for review/send
mode_out  out  $clog2(NUM_MODES) (min 1)  selected filter
countdown_out  out  $clog2(COUNTDOWN_FRAMES+1)  frames remaining
capture_en_out  out  1  frame-buffer write enable for buffer shot_idx_out
flash_out  out  1  high in ARM and CAPTURE
send_start_out  out  1  single-cycle send request
busy_out  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE.
- All outputs registered; they change one cycle after the causing input edge.
- States: IDLE=0, PREVIEW=1, COUNTDOWN=2, ARM=3, CAPTURE=4, REVIEW=5, FILTER=6, SEND=7.
- IDLE: start_in -> PREVIEW; shot_idx, review_sel and mode cleared.
- PREVIEW: start_in -> COUNTDOWN; countdown loads COUNTDOWN_FRAMES.
- COUNTDOWN: each frame_tick_in decrements the count. A tick while the count is 1 sets it to 0 and moves to ARM. frame_done_in is ignored here.
- ARM: waits for a frame boundary. frame_done_in -> CAPTURE, with capture_en_out high from the next cycle. This guarantees exactly one whole camera frame is written.
- CAPTURE: capture_en_out stays high. On frame_done_in, capture_en_out drops the next cycle.
  - If shot_idx == NUM_SHOTS-1: go to REVIEW; shot_idx holds.
  - Otherwise: shot_idx increments, countdown reloads, go to COUNTDOWN.
- REVIEW: next_in increments review_sel, wrapping NUM_SHOTS-1 -> 0. accept_in -> FILTER.
- FILTER: next_in increments mode, wrapping NUM_MODES-1 -> 0. accept_in -> SEND, and send_start_out is high for exactly the one cycle after.
- SEND: ignores next/accept/start. send_done_in -> IDLE.
- Priority: cancel_in > accept_in > next_in > start_in.
  - cancel_in in any non-IDLE state -> IDLE next cycle, capture_en_out 0, counters cleared.
  - cancel_in in IDLE has no effect.
- Asynchronous reset mid-CAPTURE drops capture_en_out immediately; a partial buffer is acceptable.
- NUM_SHOTS=1: CAPTURE goes directly to REVIEW; review_sel is constant 0.
- Illegal state encodings are unreachable; the default branch returns to IDLE.

Decomposition:
- Package photobooth_pkg holds:
  - typedef enum logic [2:0] pb_state_t (the states above);
  - localparams MODE_GRAY=0, MODE_DITHER=1, MODE_THRESH=2.
- One sub-module, frame_countdown:
  - load/tick/count interface with a zero flag;
  - asynchronous active-low reset;
  - parametrised by COUNTDOWN_FRAMES.

Test Plan:
- Defaults (NUM_SHOTS=4, COUNTDOWN_FRAMES=3), start, start, then ticks:
  - countdown_out goes 3, 2, 1, 0, then ARM.
  - After frame_done, capture_en_out is high for exactly one frame_done interval.
  - shot_idx_out steps 0->1.
- Full session of 4 shots:
  - capture_en_out asserts 4 times, shot_idx_out 0..3.
  - State ends in REVIEW(5) with shot_idx_out=3.
- REVIEW: 5 next pulses -> review_sel_out=1 (wrap). FILTER: 4 next pulses -> mode_out=1.
  - accept -> send_start_out high 1 cycle, state 7.
  - send_done -> IDLE, busy_out=0.
- cancel_in in CAPTURE mid-frame:
  - next cycle state 0, capture_en_out 0, shot_idx_out 0.
  - A subsequent frame_done causes no capture.
- Simultaneous pulses:
  - accept_in and next_in together in REVIEW -> FILTER with review_sel unchanged.
  - cancel_in and accept_in together -> IDLE.
- rst_n_in asserted asynchronously mid-CAPTURE:
  - capture_en_out 0 before the next clock edge; all outputs 0.
  - After release, start resumes normally.

Source files
------------

// File: rtl/photobooth_pkg.sv
// Shared types for the photobooth capture sequencer.
package photobooth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREVIEW   = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_ARM       = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_REVIEW    = 3'd5,
    ST_FILTER    = 3'd6,
    ST_SEND      = 3'd7
  } pb_state_t;

  localparam int unsigned MODE_GRAY   = 0;
  localparam int unsigned MODE_DITHER = 1;
  localparam int unsigned MODE_THRESH = 2;

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame-tick down-counter with a zero flag; saturates at zero.
module frame_countdown #(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  localparam int unsigned CNT_W = $clog2(COUNTDOWN_FRAMES + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic             load_in,
  input  logic             tick_in,
  output logic [CNT_W-1:0] count_out,
  output logic             zero_out
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      count_out <= '0;
    else if (clear_in)
      count_out <= '0;
    else if (load_in)
      count_out <= CNT_W'(COUNTDOWN_FRAMES);
    else if (tick_in && count_out != '0)
      count_out <= count_out - 1'b1;
  end

  assign zero_out = (count_out == '0);

endmodule

// File: rtl/photobooth_seq.sv
// Multi-shot photobooth session sequencer: preview, countdown, capture, review, filter, send.
module photobooth_seq
  import photobooth_pkg::*;
#(
  parameter int unsigned NUM_SHOTS        = 4,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned NUM_MODES        = 3,
  localparam int unsigned SHOT_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1,
  localparam int unsigned MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  localparam int unsigned CNT_W  = $clog2(COUNTDOWN_FRAMES + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              next_in,
  input  logic              accept_in,
  input  logic              cancel_in,
  input  logic              frame_tick_in,
  input  logic              frame_done_in,
  input  logic              send_done_in,
  output logic [2:0]        state_out,
  output logic [SHOT_W-1:0] shot_idx_out,
  output logic [SHOT_W-1:0] review_sel_out,
  output logic [MODE_W-1:0] mode_out,
  output logic [CNT_W-1:0]  countdown_out,
  output logic              capture_en_out,
  output logic              flash_out,
  output logic              send_start_out,
  output logic              busy_out
);

  pb_state_t         state, state_nx;
  logic [SHOT_W-1:0] shot, shot_nx, rsel, rsel_nx;
  logic [MODE_W-1:0] mode, mode_nx;
  logic              cd_clear, cd_load, cd_tick, cd_zero;
  logic              send_nx;

  frame_countdown #(.COUNTDOWN_FRAMES(COUNTDOWN_FRAMES)) u_countdown (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clear_in  (cd_clear),
    .load_in   (cd_load),
    .tick_in   (cd_tick),
    .count_out (countdown_out),
    .zero_out  (cd_zero)
  );

  always_comb begin
    state_nx = state;
    shot_nx  = shot;
    rsel_nx  = rsel;
    mode_nx  = mode;
    cd_clear = 1'b0;
    cd_load  = 1'b0;
    cd_tick  = 1'b0;
    send_nx  = 1'b0;
    if (cancel_in && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      shot_nx  = '0;
      rsel_nx  = '0;
      mode_nx  = '0;
      cd_clear = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (start_in) begin
          state_nx = ST_PREVIEW;
          shot_nx  = '0;
          rsel_nx  = '0;
          mode_nx  = '0;
        end
        ST_PREVIEW: if (start_in) begin
          state_nx = ST_COUNTDOWN;
          cd_load  = 1'b1;
        end
        ST_COUNTDOWN: if (frame_tick_in) begin
          cd_tick = 1'b1;
          // zero check covers a degenerate zero-length countdown
          if (countdown_out == CNT_W'(1) || cd_zero)
            state_nx = ST_ARM;
        end
        ST_ARM: if (frame_done_in)
          state_nx = ST_CAPTURE;
        ST_CAPTURE: if (frame_done_in) begin
          if (shot == SHOT_W'(NUM_SHOTS - 1)) begin
            state_nx = ST_REVIEW;
          end else begin
            shot_nx  = shot + 1'b1;
            cd_load  = 1'b1;
            state_nx = ST_COUNTDOWN;
          end
        end
        ST_REVIEW: begin
          if (accept_in)
            state_nx = ST_FILTER;
          else if (next_in)
            rsel_nx = (rsel == SHOT_W'(NUM_SHOTS - 1)) ? '0 : rsel + 1'b1;
        end
        ST_FILTER: begin
          if (accept_in) begin
            state_nx = ST_SEND;
            send_nx  = 1'b1;
          end else if (next_in) begin
            mode_nx = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
          end
        end
        ST_SEND: if (send_done_in)
          state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Strobes are registered from next-state so async reset clears them with the state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      shot           <= '0;
      rsel           <= '0;
      mode           <= '0;
      capture_en_out <= 1'b0;
      flash_out      <= 1'b0;
      send_start_out <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      state          <= state_nx;
      shot           <= shot_nx;
      rsel           <= rsel_nx;
      mode           <= mode_nx;
      capture_en_out <= (state_nx == ST_CAPTURE);
      flash_out      <= (state_nx == ST_ARM) || (state_nx == ST_CAPTURE);
      send_start_out <= send_nx;
      busy_out       <= (state_nx != ST_IDLE);
    end
  end

  assign state_out      = state;
  assign shot_idx_out   = shot;
  assign review_sel_out = rsel;
  assign mode_out       = mode;

endmodule

// File: tb/tb_photobooth_seq.sv
// Directed scoreboard bench for photobooth_seq (4 shots, 3-frame countdown, 3 modes).
module tb_photobooth_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_p, next_p, accept_p, cancel_p, tick_p, fd_p, sd_p;
  logic [2:0] state_out;
  logic [1:0] shot_idx_out, review_sel_out, mode_out, countdown_out;
  logic       capture_en_out, flash_out, send_start_out, busy_out;

  photobooth_seq #(.NUM_SHOTS(4), .COUNTDOWN_FRAMES(3), .NUM_MODES(3)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .start_in       (start_p),
    .next_in        (next_p),
    .accept_in      (accept_p),
    .cancel_in      (cancel_p),
    .frame_tick_in  (tick_p),
    .frame_done_in  (fd_p),
    .send_done_in   (sd_p),
    .state_out      (state_out),
    .shot_idx_out   (shot_idx_out),
    .review_sel_out (review_sel_out),
    .mode_out       (mode_out),
    .countdown_out  (countdown_out),
    .capture_en_out (capture_en_out),
    .flash_out      (flash_out),
    .send_start_out (send_start_out),
    .busy_out       (busy_out)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] shot;
    logic [1:0] rsel;
    logic [1:0] mode;
    logic [1:0] cnt;
    logic       cap;
    logic       flash;
    logic       snd;
    logic       busy;
  } obs_t;

  localparam logic [6:0] P_NONE   = 7'b0000000;
  localparam logic [6:0] P_START  = 7'b1000000;
  localparam logic [6:0] P_NEXT   = 7'b0100000;
  localparam logic [6:0] P_ACCEPT = 7'b0010000;
  localparam logic [6:0] P_CANCEL = 7'b0001000;
  localparam logic [6:0] P_TICK   = 7'b0000100;
  localparam logic [6:0] P_FD     = 7'b0000010;
  localparam logic [6:0] P_SD     = 7'b0000001;

  obs_t sb[$];
  obs_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.st    = state_out;
    o.shot  = shot_idx_out;
    o.rsel  = review_sel_out;
    o.mode  = mode_out;
    o.cnt   = countdown_out;
    o.cap   = capture_en_out;
    o.flash = flash_out;
    o.snd   = send_start_out;
    o.busy  = busy_out;
    return o;
  endfunction

  task automatic check(input string tag);
    obs_t got, want;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
    end else begin
      want = sb.pop_front();
      got  = sample();
      total++;
      assert (got === want)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
    end
  endtask

  // Push the expectation, pulse inputs for one cycle, then check after the edge.
  task automatic cyc(input logic [6:0] p, input string tag);
    sb.push_back(e);
    @(negedge clk);
    {start_p, next_p, accept_p, cancel_p, tick_p, fd_p, sd_p} = p;
    @(posedge clk);
    #1;
    {start_p, next_p, accept_p, cancel_p, tick_p, fd_p, sd_p} = P_NONE;
    check(tag);
  endtask

  // From COUNTDOWN with count 3: run down to ARM, then enter CAPTURE.
  task automatic to_capture();
    e.cnt = 2'd2;                          cyc(P_TICK, "cd_2");
    e.cnt = 2'd1;                          cyc(P_TICK, "cd_1");
    e.cnt = 2'd0; e.st = 3'd3; e.flash = 1; cyc(P_TICK, "cd_0_arm");
    cyc(P_NONE, "arm_wait");
    e.st = 3'd4; e.cap = 1'b1;             cyc(P_FD, "cap_on");
  endtask

  task automatic run_shot(input logic [1:0] k, input bit last);
    to_capture();
    cyc(P_NONE, "cap_hold_a");
    cyc(P_TICK, "cap_hold_tick");
    e.cap = 1'b0; e.flash = 1'b0;
    if (last) begin
      e.st = 3'd5;
    end else begin
      e.st = 3'd2; e.cnt = 2'd3; e.shot = k + 2'd1;
    end
    cyc(P_FD, last ? "cap_off_review" : "cap_off_next");
  endtask

  initial begin
    rst_n = 1'b0;
    {start_p, next_p, accept_p, cancel_p, tick_p, fd_p, sd_p} = P_NONE;
    e = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(e);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    e.st = 3'd1; e.busy = 1'b1;  cyc(P_START, "idle_to_preview");
    e.st = 3'd2; e.cnt = 2'd3;   cyc(P_START, "preview_to_cd");
    cyc(P_FD, "fd_ignored_in_cd");

    run_shot(2'd0, 1'b0);
    run_shot(2'd1, 1'b0);
    run_shot(2'd2, 1'b0);
    run_shot(2'd3, 1'b1);

    e.rsel = 2'd1; cyc(P_NEXT, "rsel_1");
    e.rsel = 2'd2; cyc(P_NEXT, "rsel_2");
    e.rsel = 2'd3; cyc(P_NEXT, "rsel_3");
    e.rsel = 2'd0; cyc(P_NEXT, "rsel_wrap");
    e.rsel = 2'd1; cyc(P_NEXT, "rsel_1_again");
    e.st = 3'd6;   cyc(P_ACCEPT | P_NEXT, "accept_beats_next");

    e.mode = 2'd1; cyc(P_NEXT, "mode_1");
    e.mode = 2'd2; cyc(P_NEXT, "mode_2");
    e.mode = 2'd0; cyc(P_NEXT, "mode_wrap");
    e.mode = 2'd1; cyc(P_NEXT, "mode_1_again");
    e.st = 3'd7; e.snd = 1'b1; cyc(P_ACCEPT, "send_start");
    e.snd = 1'b0;              cyc(P_NONE, "send_start_one_cycle");
    cyc(P_START | P_NEXT | P_ACCEPT, "send_ignores_inputs");
    e.st = 3'd0; e.busy = 1'b0; cyc(P_SD, "send_done_idle");
    cyc(P_CANCEL, "cancel_in_idle_noop");

    e = '0; e.st = 3'd1; e.busy = 1'b1; cyc(P_START, "restart_clears");
    e.st = 3'd2; e.cnt = 2'd3;          cyc(P_START, "restart_cd");
    to_capture();
    cyc(P_NONE, "cap_mid_frame");
    e = '0; cyc(P_CANCEL, "cancel_in_capture");
    cyc(P_FD, "no_capture_after_cancel");

    e.st = 3'd1; e.busy = 1'b1; cyc(P_START, "preview_again");
    e = '0;                     cyc(P_CANCEL | P_ACCEPT, "cancel_beats_accept");

    e.st = 3'd1; e.busy = 1'b1; cyc(P_START, "preview_pre_rst");
    e.st = 3'd2; e.cnt = 2'd3;  cyc(P_START, "cd_pre_rst");
    to_capture();
    e = '0;
    sb.push_back(e);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_capture");
    @(negedge clk);
    rst_n = 1'b1;
    e.st = 3'd1; e.busy = 1'b1; cyc(P_START, "start_after_reset");
    e.st = 3'd2; e.cnt = 2'd3;  cyc(P_START, "cd_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
